// File: rtl/inst_buffer.sv
// Instruction buffer between fetch and dispatch: a circular queue that accepts up to
// two instructions per cycle and presents the two oldest to dispatch.

package inst_buffer_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc;
    } IF_INST_OUT;
endpackage

module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int NUM_ENTRIES = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  IF_INST_OUT [1:0] if_insts_in,
    input  logic       [1:0] num_if_in,
    input  logic       [1:0] num_to_dispatch,
    output IF_INST_OUT [1:0] fetched_insts,
    output logic       [1:0] num_valid_insts,
    output logic       [1:0] num_can_accept,
    output logic             empty
);

    localparam int PTR_W = $clog2(NUM_ENTRIES);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    IF_INST_OUT entries_q [NUM_ENTRIES];
    IF_INST_OUT entries_d [NUM_ENTRIES];
    ptr_t       head_q, head_d;
    ptr_t       tail_q, tail_d;
    cnt_t       count_q, count_d;
    cnt_t       free_slots;
    logic [1:0] enq;
    logic [1:0] deq;

    // Outputs depend only on registered state, so fetch and dispatch never see a bypass.
    always_comb begin
        free_slots      = cnt_t'(NUM_ENTRIES) - count_q;
        num_valid_insts = (count_q >= cnt_t'(2)) ? 2'd2 : count_q[1:0];
        num_can_accept  = (free_slots >= cnt_t'(2)) ? 2'd2 : free_slots[1:0];
        empty           = (count_q == '0);
        fetched_insts   = '0;
        if (num_valid_insts != 2'd0) begin
            fetched_insts[0] = entries_q[head_q];
        end
        if (num_valid_insts == 2'd2) begin
            fetched_insts[1] = entries_q[head_q + ptr_t'(1)];
        end
    end

    always_comb begin
        enq       = (num_if_in > num_can_accept) ? num_can_accept : num_if_in;
        deq       = (num_to_dispatch > num_valid_insts) ? num_valid_insts : num_to_dispatch;
        entries_d = entries_q;
        head_d    = head_q + ptr_t'(deq);
        tail_d    = tail_q + ptr_t'(enq);
        count_d   = count_q + cnt_t'(enq) - cnt_t'(deq);
        if (enq != 2'd0) begin
            entries_d[tail_q] = if_insts_in[0];
        end
        if (enq == 2'd2) begin
            entries_d[tail_q + ptr_t'(1)] = if_insts_in[1];
        end
        // Stale entries left behind by a flush are unreachable once count is zero.
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        entries_q <= entries_d;
    end

endmodule

// File: tb/tb_inst_buffer.sv
// Scoreboard bench for inst_buffer: directed steps push hand-computed expected outputs,
// a negedge monitor pops and compares them against what the buffer presents.

module tb_inst_buffer;
    import inst_buffer_pkg::*;

    localparam logic [31:0] NONE = 32'hFFFF_FFFF;

    typedef struct {
        int         nv;
        int         can;
        bit         emp;
        IF_INST_OUT f0;
        IF_INST_OUT f1;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             flush = 1'b0;
    IF_INST_OUT [1:0] if_insts_in = '0;
    logic       [1:0] num_if_in = 2'd0;
    logic       [1:0] num_to_dispatch = 2'd0;
    IF_INST_OUT [1:0] fetched_insts;
    logic       [1:0] num_valid_insts;
    logic       [1:0] num_can_accept;
    logic             empty;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    inst_buffer #(.NUM_ENTRIES(8)) dut (
        .clock          (clock),
        .reset          (reset),
        .flush          (flush),
        .if_insts_in    (if_insts_in),
        .num_if_in      (num_if_in),
        .num_to_dispatch(num_to_dispatch),
        .fetched_insts  (fetched_insts),
        .num_valid_insts(num_valid_insts),
        .num_can_accept (num_can_accept),
        .empty          (empty)
    );

    always #5 clock = ~clock;

    function automatic IF_INST_OUT mk(input logic [31:0] pc);
        IF_INST_OUT r;
        r.valid = 1'b1;
        r.inst  = 32'h0013_0000 ^ pc;
        r.pc    = pc;
        return r;
    endfunction

    function automatic IF_INST_OUT mk_exp(input logic [31:0] pc);
        if (pc == NONE) return '0;
        return mk(pc);
    endfunction

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: one expected record per cycle, compared away from the active edge.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("num_valid_insts", 65'(num_valid_insts), 65'(e.nv));
            check("num_can_accept", 65'(num_can_accept), 65'(e.can));
            check("empty", 65'(empty), 65'(e.emp));
            check("fetched_insts[0]", 65'(fetched_insts[0]), 65'(e.f0));
            check("fetched_insts[1]", 65'(fetched_insts[1]), 65'(e.f1));
        end
    end

    task automatic step(input bit rst, input bit fl, input int nif, input int nd,
                        input logic [31:0] p0, input logic [31:0] p1,
                        input int env, input int ecan, input bit eemp,
                        input logic [31:0] e0, input logic [31:0] e1);
        exp_t e;
        reset           = rst;
        flush           = fl;
        num_if_in       = 2'(nif);
        num_to_dispatch = 2'(nd);
        if_insts_in[0]  = mk(p0);
        if_insts_in[1]  = mk(p1);
        @(posedge clock);
        e.nv  = env;
        e.can = ecan;
        e.emp = eemp;
        e.f0  = mk_exp(e0);
        e.f1  = mk_exp(e1);
        exp_q.push_back(e);
        @(negedge clock);
    endtask

    initial begin
        // rst fl nif nd  pc0 pc1            nv can emp head tail
        step(1, 0, 2, 2, 32'h900, 32'h904, 0, 2, 1, NONE, NONE);
        // Fill to full, then an extra pair is dropped.
        step(0, 0, 2, 0, 32'h00, 32'h04, 2, 2, 0, 32'h00, 32'h04);
        step(0, 0, 2, 0, 32'h08, 32'h0C, 2, 2, 0, 32'h00, 32'h04);
        step(0, 0, 2, 0, 32'h10, 32'h14, 2, 2, 0, 32'h00, 32'h04);
        step(0, 0, 2, 0, 32'h18, 32'h1C, 2, 0, 0, 32'h00, 32'h04);
        step(0, 0, 2, 0, 32'h20, 32'h24, 2, 0, 0, 32'h00, 32'h04);
        // count 7: only slot 0 accepted.
        step(0, 0, 0, 1, 32'hDEAD, 32'hBEEF, 2, 1, 0, 32'h04, 32'h08);
        step(0, 0, 2, 0, 32'h20, 32'h24, 2, 0, 0, 32'h04, 32'h08);
        // Drain; the pair 0x1C/0x20 straddles entries 7 and 0.
        step(0, 0, 0, 2, 32'h0, 32'h0, 2, 2, 0, 32'h0C, 32'h10);
        step(0, 0, 0, 2, 32'h0, 32'h0, 2, 2, 0, 32'h14, 32'h18);
        step(0, 0, 0, 2, 32'h0, 32'h0, 2, 2, 0, 32'h1C, 32'h20);
        step(0, 0, 0, 2, 32'h0, 32'h0, 0, 2, 1, NONE, NONE);
        // Simultaneous enqueue/dequeue at count 3.
        step(0, 0, 2, 0, 32'h30, 32'h34, 2, 2, 0, 32'h30, 32'h34);
        step(0, 0, 1, 0, 32'h38, 32'hDEAD, 2, 2, 0, 32'h30, 32'h34);
        step(0, 0, 2, 2, 32'h3C, 32'h40, 2, 2, 0, 32'h38, 32'h3C);
        // Odd count: dequeue of 2 clamps.
        step(0, 0, 0, 2, 32'h0, 32'h0, 1, 2, 0, 32'h40, NONE);
        step(0, 0, 0, 2, 32'h0, 32'h0, 0, 2, 1, NONE, NONE);
        // Move head/tail to 7, then enqueue across the wrap point.
        step(0, 0, 1, 0, 32'h50, 32'hDEAD, 1, 2, 0, 32'h50, NONE);
        step(0, 0, 0, 1, 32'h0, 32'h0, 0, 2, 1, NONE, NONE);
        step(0, 0, 2, 0, 32'h100, 32'h104, 2, 2, 0, 32'h100, 32'h104);
        // Flush at count 5 ignores that cycle's enqueue and dequeue; repeat flush stays empty.
        step(0, 0, 2, 0, 32'h108, 32'h10C, 2, 2, 0, 32'h100, 32'h104);
        step(0, 0, 1, 0, 32'h110, 32'hDEAD, 2, 2, 0, 32'h100, 32'h104);
        step(0, 1, 2, 1, 32'h200, 32'h204, 0, 2, 1, NONE, NONE);
        step(0, 1, 2, 0, 32'h208, 32'h20C, 0, 2, 1, NONE, NONE);
        step(0, 0, 2, 0, 32'h300, 32'h304, 2, 2, 0, 32'h300, 32'h304);
        step(0, 0, 1, 0, 32'h308, 32'hDEAD, 2, 2, 0, 32'h300, 32'h304);
        // Reset together with flush and enqueue.
        step(1, 1, 2, 0, 32'h310, 32'h314, 0, 2, 1, NONE, NONE);
        // Mid-stream reset.
        step(0, 0, 2, 0, 32'h400, 32'h404, 2, 2, 0, 32'h400, 32'h404);
        step(0, 0, 1, 0, 32'h408, 32'hDEAD, 2, 2, 0, 32'h400, 32'h404);
        step(1, 0, 2, 1, 32'h40C, 32'h410, 0, 2, 1, NONE, NONE);
        step(0, 0, 2, 0, 32'h500, 32'h504, 2, 2, 0, 32'h500, 32'h504);
        step(0, 0, 0, 1, 32'h0, 32'h0, 1, 2, 0, 32'h504, NONE);

        num_if_in       = 2'd0;
        num_to_dispatch = 2'd0;
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clock);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
